// File: rtl/traffic_light_sequencer_pkg.sv
// traffic_light_sequencer_pkg: phase encoding, lamp codes and lamp decode helpers
package traffic_light_sequencer_pkg;

    typedef enum logic [2:0] {
        INIT_RED,
        MAIN_G,
        MAIN_Y,
        RED_A,
        SIDE_G,
        SIDE_Y,
        RED_B,
        WALK
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    function automatic logic [2:0] main_lamp(input state_t s);
        return (s == MAIN_G) ? LAMP_GRN : (s == MAIN_Y) ? LAMP_YEL : LAMP_RED;
    endfunction

    function automatic logic [2:0] side_lamp(input state_t s);
        return (s == SIDE_G) ? LAMP_GRN : (s == SIDE_Y) ? LAMP_YEL : LAMP_RED;
    endfunction

endpackage

// File: rtl/traffic_light_sequencer.sv
// traffic_light_sequencer: steps the intersection phases, arming the external timer once per phase
module traffic_light_sequencer
    import traffic_light_sequencer_pkg::*;
#(
    parameter int T_MAIN_GREEN = 30,
    parameter int T_MAIN_EXT   = 10,
    parameter int T_YELLOW     = 4,
    parameter int T_ALL_RED    = 2,
    parameter int T_SIDE_GREEN = 15,
    parameter int T_WALK       = 10,
    parameter int TW           = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          side_car,
    input  logic          ped_req,
    input  logic          expired,
    output logic          start_timer,
    output logic [TW-1:0] time_param,
    output logic [2:0]    main_light,
    output logic [2:0]    side_light,
    output logic          walk
);

    state_t        state;
    state_t        nxt;
    logic          armed;
    logic          ext;
    logic          side_pend;
    logic          ped_pend;
    logic [TW-1:0] dur;
    logic          to_side;
    logic          to_walk;

    // duration for the current phase; ext selects the main-green extension after a quiet green
    always_comb begin
        dur = (state == MAIN_G) ? (ext ? TW'(T_MAIN_EXT) : TW'(T_MAIN_GREEN)) :
              (state == MAIN_Y || state == SIDE_Y) ? TW'(T_YELLOW) :
              (state == SIDE_G) ? TW'(T_SIDE_GREEN) :
              (state == WALK) ? TW'(T_WALK) : TW'(T_ALL_RED);
    end

    // phase taken when the armed timer expires
    always_comb begin
        nxt = INIT_RED;
        case (state)
            INIT_RED: nxt = MAIN_G;
            MAIN_G:   nxt = (side_pend | ped_pend) ? MAIN_Y : MAIN_G;
            MAIN_Y:   nxt = RED_A;
            RED_A:    nxt = side_pend ? SIDE_G : WALK;
            SIDE_G:   nxt = SIDE_Y;
            SIDE_Y:   nxt = RED_B;
            RED_B:    nxt = ped_pend ? WALK : MAIN_G;
            WALK:     nxt = MAIN_G;
            default:  nxt = INIT_RED;
        endcase
    end

    assign to_side = armed && expired && nxt == SIDE_G;
    assign to_walk = armed && expired && nxt == WALK;

    // arm/wait sequencing, request latches (set beats clear) and registered lamp decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= INIT_RED;
            armed       <= 1'b0;
            ext         <= 1'b0;
            start_timer <= 1'b0;
            time_param  <= '0;
            main_light  <= LAMP_RED;
            side_light  <= LAMP_RED;
            walk        <= 1'b0;
            side_pend   <= 1'b0;
            ped_pend    <= 1'b0;
        end else begin
            side_pend <= side_car | (side_pend & ~to_side);
            ped_pend  <= ped_req | (ped_pend & ~to_walk);
            if (!armed) begin
                start_timer <= 1'b1;
                time_param  <= dur;
                armed       <= 1'b1;
            end else begin
                start_timer <= 1'b0;
                if (expired) begin
                    state      <= nxt;
                    armed      <= 1'b0;
                    ext        <= (state == MAIN_G) && (nxt == MAIN_G);
                    main_light <= main_lamp(nxt);
                    side_light <= side_lamp(nxt);
                    walk       <= (nxt == WALK);
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// tb_traffic_light_sequencer: random requests against a phase-level reference model and a scaled timer
module tb_traffic_light_sequencer;

    localparam int SC = 3;
    localparam int P_INIT = 0, P_MG = 1, P_MY = 2, P_RA = 3, P_SG = 4, P_SY = 5, P_RB = 6, P_WK = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       side_car = 1'b0;
    logic       ped_req = 1'b0;
    logic       expired = 1'b0;
    logic       start_timer;
    logic [6:0] time_param;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;

    int vecs = 0;
    int errs = 0;

    int dur_tab[8] = '{2, 30, 4, 2, 15, 4, 2, 10};
    int m_ph, m_tp, t_cnt;
    bit m_armed, m_ext, m_sp, m_pp, m_st, t_real, glitch;
    bit side_left_red, saw_ext, saw_walk, saw_sg;

    always #5 clk = ~clk;

    traffic_light_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .side_car   (side_car),
        .ped_req    (ped_req),
        .expired    (expired),
        .start_timer(start_timer),
        .time_param (time_param),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] m_main(input int p);
        return p == P_MG ? 3'b001 : p == P_MY ? 3'b010 : 3'b100;
    endfunction

    function automatic logic [2:0] m_side(input int p);
        return p == P_SG ? 3'b001 : p == P_SY ? 3'b010 : 3'b100;
    endfunction

    task automatic model_reset();
        m_ph = P_INIT; m_armed = 0; m_ext = 0; m_sp = 0; m_pp = 0; m_st = 0; m_tp = 0;
        t_cnt = 0; t_real = 0;
    endtask

    task automatic model_step(input bit sc, input bit pr, input bit ex);
        int nx;
        nx = m_ph;
        if (!m_armed) begin
            m_st = 1;
            m_tp = (m_ph == P_MG && m_ext) ? 10 : dur_tab[m_ph];
            m_armed = 1;
        end else begin
            m_st = 0;
            if (ex) begin
                case (m_ph)
                    P_INIT: nx = P_MG;
                    P_MG:   nx = (m_sp || m_pp) ? P_MY : P_MG;
                    P_MY:   nx = P_RA;
                    P_RA:   nx = m_sp ? P_SG : P_WK;
                    P_SG:   nx = P_SY;
                    P_SY:   nx = P_RB;
                    P_RB:   nx = m_pp ? P_WK : P_MG;
                    default: nx = P_MG;
                endcase
                m_ext = (m_ph == P_MG && nx == P_MG);
                m_armed = 0;
            end
        end
        m_sp = sc || (m_sp && !(nx == P_SG && m_ph != P_SG));
        m_pp = pr || (m_pp && !(nx == P_WK && m_ph != P_WK));
        m_ph = nx;
    endtask

    task automatic tick(input bit sc, input bit pr);
        bit ex;
        ex = 0;
        if (start_timer) begin
            t_cnt = int'(time_param) * SC;
            t_real = 0;
        end else if (t_cnt > 0) begin
            t_cnt--;
            ex = (t_cnt == 0);
            t_real = ex;
        end else begin
            ex = t_real && glitch;
            t_real = 0;
        end
        side_car = sc; ped_req = pr; expired = ex;
        model_step(sc, pr, ex);
        @(negedge clk);
        chk("outs", {start_timer, time_param, main_light, side_light, walk},
            {m_st, m_tp[6:0], m_main(m_ph), m_side(m_ph), m_ph == P_WK});
        chk("pend", {dut.side_pend, dut.ped_pend}, {m_sp, m_pp});
        chk("safety", main_light != 3'b100 && side_light != 3'b100, 0);
        if (side_light != 3'b100) side_left_red = 1;
        if (start_timer && time_param == 7'd10 && main_light == 3'b001) saw_ext = 1;
        if (walk) saw_walk = 1;
        if (m_ph == P_SG) saw_sg = 1;
    endtask

    initial begin
        model_reset();
        glitch = 1;
        repeat (3) @(negedge clk);
        chk("rst_outs", {start_timer, time_param, main_light, side_light, walk}, {1'b0, 7'd0, 3'b100, 3'b100, 1'b0});
        reset = 1'b1;
        tick(0, 0);
        chk("init_strobe", {start_timer, time_param}, {1'b1, 7'd2});
        repeat (7) tick(0, 0);
        chk("init_to_mg", main_light, 3'b001);
        side_left_red = 0;
        repeat (300) tick(0, 0);
        chk("quiet_side_red", side_left_red, 0);
        chk("quiet_ext", saw_ext, 1);
        chk("quiet_main_grn", main_light, 3'b001);
        tick(1, 0);
        repeat (250) tick(0, 0);
        chk("side_served", saw_sg, 1);
        chk("side_done_mg", main_light, 3'b001);
        tick(1, 1);
        repeat (350) tick(0, 0);
        chk("walk_served", saw_walk, 1);
        for (int i = 0; i < 3000; i++) begin
            glitch = ($urandom_range(0, 1) == 1);
            tick($urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0);
        end
        begin
            int n;
            n = 0;
            while (m_ph != P_SG && n < 2000) begin
                tick($urandom_range(0, 9) == 0, 0);
                n++;
            end
            chk("reach_sg", m_ph == P_SG, 1);
        end
        repeat (5) tick(0, 0);
        reset = 1'b0;
        expired = 1'b0;
        #1;
        chk("async_rst", {start_timer, time_param, main_light, side_light, walk}, {1'b0, 7'd0, 3'b100, 3'b100, 1'b0});
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        tick(0, 0);
        chk("rearm_init", {start_timer, time_param, main_light}, {1'b1, 7'd2, 3'b100});
        for (int i = 0; i < 800; i++) tick($urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
